scoreboard_hazard_unit: RTL and testbench

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/haz_pkg.sv | 23 ++
 rtl/scoreboard_hazard_unit_if.sv | 41 ++++
 rtl/haz_scoreboard.sv | 59 +++++
 rtl/scoreboard_hazard_unit.sv | 139 +++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/haz_pkg.sv
// Shared types and constants for the scoreboard hazard unit.
package haz_pkg;

    // Default parameter values for the hazard unit.
    localparam int unsigned DEF_NUM_REGS  = 8;
    localparam int unsigned DEF_LOAD_LAT  = 2;
    localparam int unsigned DEF_FLAG_LAT  = 1;
    localparam int unsigned DEF_BR_SHADOW = 1;

    // Counter widths: LOAD_LAT <= 4, FLAG_LAT <= 3, BR_SHADOW <= 3.
    localparam int unsigned REG_CNT_W    = 3;
    localparam int unsigned FLAG_CNT_W   = 2;
    localparam int unsigned SHADOW_CNT_W = 2;
    localparam int unsigned PERF_CNT_W   = 16;

    // Hazard unit control state.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SHADOW = 2'd2
    } haz_state_e;

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode-stage <-> hazard unit bundle: decoded instruction fields in,
// pipeline steering and scoreboard bitmap out.
interface scoreboard_hazard_unit_if
    import haz_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS
);
    localparam int unsigned RW = $clog2(NUM_REGS);

    logic                id_valid;
    logic [RW-1:0]       id_rs1;
    logic [RW-1:0]       id_rs2;
    logic                id_rs1_used;
    logic                id_rs2_used;
    logic [RW-1:0]       id_rd;
    logic                id_rd_we;
    logic                id_is_load;
    logic                id_is_branch;
    logic                id_flag_we;

    logic                pc_write;
    logic                if_write;
    logic                idex_flush;
    logic                if_flush;
    logic [NUM_REGS-1:0] busy_regs;

    // Decode stage side.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load, id_is_branch, id_flag_we,
        input  pc_write, if_write, idex_flush, if_flush, busy_regs
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load, id_is_branch, id_flag_we,
        output pc_write, if_write, idex_flush, if_flush, busy_regs
    );

endinterface

// File: rtl/haz_scoreboard.sv
// Per-register pending-load down-counters plus a flag-pending counter.
// A set loads the latency and wins over the decrement in the same cycle;
// busy outputs are registered copies of (counter != 0).
module haz_scoreboard
    import haz_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
    parameter int unsigned FLAG_LAT = DEF_FLAG_LAT,
    parameter int unsigned RW       = $clog2(NUM_REGS)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [RW-1:0]       set_idx,
    input  logic                flag_set_en,
    output logic [NUM_REGS-1:0] busy,
    output logic                flag_busy
);

    logic [REG_CNT_W-1:0]  cnt      [NUM_REGS];
    logic [REG_CNT_W-1:0]  cnt_nxt  [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_nxt;
    logic [FLAG_CNT_W-1:0] flag_cnt;
    logic [FLAG_CNT_W-1:0] flag_cnt_nxt;

    // Next counter values: decrement toward zero, a set overrides.
    always_comb begin
        busy_nxt = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            cnt_nxt[i] = (cnt[i] != '0) ? (cnt[i] - REG_CNT_W'(1)) : '0;
            if (set_en && (set_idx == RW'(i))) begin
                cnt_nxt[i] = REG_CNT_W'(LOAD_LAT);
            end
            busy_nxt[i] = (cnt_nxt[i] != '0);
        end

        flag_cnt_nxt = (flag_cnt != '0) ? (flag_cnt - FLAG_CNT_W'(1)) : '0;
        if (flag_set_en) begin
            flag_cnt_nxt = FLAG_CNT_W'(FLAG_LAT);
        end
    end

    // Counter and busy-bit registers; reset discards all pending entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '{default: '0};
            busy      <= '0;
            flag_cnt  <= '0;
            flag_busy <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            busy      <= busy_nxt;
            flag_cnt  <= flag_cnt_nxt;
            flag_busy <= (flag_cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// In-order pipeline hazard unit: stalls decode on RAW/WAW hazards against
// pending loads and on branches waiting for flags, and squashes the
// wrong-path fetch shadow after a branch issues.
// Optional: define HAZ_PERF_CNT_EN to add saturating stall_cycles and
// shadow_cycles performance counters.
module scoreboard_hazard_unit
    import haz_pkg::*;
#(
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter int unsigned LOAD_LAT  = DEF_LOAD_LAT,
    parameter int unsigned FLAG_LAT  = DEF_FLAG_LAT,
    parameter int unsigned BR_SHADOW = DEF_BR_SHADOW
)(
    input  logic                     clk,
    input  logic                     reset,
    scoreboard_hazard_unit_if.slave  bus
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0]    stall_cycles,
    output logic [PERF_CNT_W-1:0]    shadow_cycles
`endif
);

    localparam int unsigned RW = $clog2(NUM_REGS);

    haz_state_e              state;
    haz_state_e              state_nxt;
    logic [SHADOW_CNT_W-1:0] shadow_cnt;
    logic [SHADOW_CNT_W-1:0] shadow_cnt_nxt;

    logic [NUM_REGS-1:0]     busy;
    logic                    flag_busy;
    logic                    in_shadow;
    logic                    src_hazard;
    logic                    hazard;
    logic                    issue;
    logic                    load_set;
    logic                    flag_set;

    // Same-cycle hazard detection against the registered scoreboard.
    assign in_shadow  = (state == SHADOW);
    assign src_hazard = (bus.id_rs1_used  && busy[bus.id_rs1])
                     || (bus.id_rs2_used  && busy[bus.id_rs2])
                     || (bus.id_is_branch && flag_busy)
                     || (bus.id_rd_we     && busy[bus.id_rd]);
    assign hazard     = bus.id_valid && !in_shadow && src_hazard;
    assign issue      = bus.id_valid && !in_shadow && !hazard;
    assign load_set   = issue && bus.id_is_load && bus.id_rd_we;
    assign flag_set   = issue && bus.id_flag_we;

    assign bus.busy_regs = busy;

    // Pending-result tracking for registers and flags.
    haz_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .LOAD_LAT (LOAD_LAT),
        .FLAG_LAT (FLAG_LAT),
        .RW       (RW)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (load_set),
        .set_idx     (bus.id_rd),
        .flag_set_en (flag_set),
        .busy        (busy),
        .flag_busy   (flag_busy)
    );

    // Control state register; reset aborts STALL/SHADOW immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            shadow_cnt <= '0;
        end else begin
            state      <= state_nxt;
            shadow_cnt <= shadow_cnt_nxt;
        end
    end

    // Next-state and pipeline steering outputs.
    always_comb begin
        state_nxt      = state;
        shadow_cnt_nxt = shadow_cnt;
        bus.pc_write   = 1'b1;
        bus.if_write   = 1'b1;
        bus.idex_flush = 1'b0;
        bus.if_flush   = 1'b0;

        case (state)
            RUN, STALL: begin
                if (hazard) begin
                    bus.pc_write   = 1'b0;
                    bus.if_write   = 1'b0;
                    bus.idex_flush = 1'b1;
                end
                if (issue && bus.id_is_branch && (BR_SHADOW > 0)) begin
                    state_nxt      = SHADOW;
                    shadow_cnt_nxt = SHADOW_CNT_W'(BR_SHADOW - 1);
                end else if (hazard) begin
                    state_nxt = STALL;
                end else begin
                    state_nxt = RUN;
                end
            end
            SHADOW: begin
                // Fetch keeps moving on the corrected path; the wrong-path
                // IF/ID contents are squashed and nothing issues.
                bus.if_flush   = 1'b1;
                bus.idex_flush = 1'b1;
                if (shadow_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    shadow_cnt_nxt = shadow_cnt - SHADOW_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating performance counters for stall and shadow cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            shadow_cycles <= '0;
        end else begin
            if (hazard && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_CNT_W'(1);
            end
            if (in_shadow && (shadow_cycles != '1)) begin
                shadow_cycles <= shadow_cycles + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed scenarios plus random traffic,
// checked cycle by cycle against a "busy until cycle N" reference model.
module tb_scoreboard_hazard_unit;

    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned LOAD_LAT  = 2;
    localparam int unsigned FLAG_LAT  = 1;
    localparam int unsigned BR_SHADOW = 2;
    localparam int unsigned RW        = $clog2(NUM_REGS);

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    scoreboard_hazard_unit_if #(.NUM_REGS(NUM_REGS)) bus_if ();

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] shadow_cycles;
`endif

    scoreboard_hazard_unit #(
        .NUM_REGS  (NUM_REGS),
        .LOAD_LAT  (LOAD_LAT),
        .FLAG_LAT  (FLAG_LAT),
        .BR_SHADOW (BR_SHADOW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .shadow_cycles (shadow_cycles)
`endif
    );

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rs1;
        logic          u1;
        logic [RW-1:0] rs2;
        logic          u2;
        logic [RW-1:0] rd;
        logic          we;
        logic          ld;
        logic          br;
        logic          fw;
    } ins_t;

    typedef struct packed {
        logic                pc_write;
        logic                if_write;
        logic                idex_flush;
        logic                if_flush;
        logic [NUM_REGS-1:0] busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   obs_stalls = 0;
    int   obs_flush  = 0;

    // Reference model: a resource is busy while the cycle number is below
    // the cycle at which its result becomes available.
    int cyc          = 0;
    int busy_until [NUM_REGS];
    int flag_until   = 0;
    int shadow_until = 0;
    int m_stall      = 0;
    int m_shadow     = 0;

    function automatic ins_t mk(input logic v, input int rs1, input logic u1,
                                input int rs2, input logic u2, input int rd,
                                input logic we, input logic ld, input logic br,
                                input logic fw);
        ins_t i;
        i.v   = v;
        i.rs1 = RW'(rs1);
        i.u1  = u1;
        i.rs2 = RW'(rs2);
        i.u2  = u2;
        i.rd  = RW'(rd);
        i.we  = we;
        i.ld  = ld;
        i.br  = br;
        i.fw  = fw;
        return i;
    endfunction

    function automatic int pick_reg();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NUM_REGS - 1));
        return int'($urandom_range(0, 3));
    endfunction

    function automatic ins_t rand_ins();
        return mk($urandom_range(0, 9) != 0,
                  pick_reg(), $urandom_range(0, 1) == 0,
                  pick_reg(), $urandom_range(0, 2) == 0,
                  pick_reg(), $urandom_range(0, 1) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0);
    endfunction

    // Drive one decode cycle, queue the expected response, advance the model.
    task automatic step(input ins_t ins, input bit rst, output bit hz);
        exp_t e;
        bit   sh;
        bit   fb;
        bit   iss;
        bus_if.id_valid     = ins.v;
        bus_if.id_rs1       = ins.rs1;
        bus_if.id_rs2       = ins.rs2;
        bus_if.id_rs1_used  = ins.u1;
        bus_if.id_rs2_used  = ins.u2;
        bus_if.id_rd        = ins.rd;
        bus_if.id_rd_we     = ins.we;
        bus_if.id_is_load   = ins.ld;
        bus_if.id_is_branch = ins.br;
        bus_if.id_flag_we   = ins.fw;
        reset               = rst;

        sh  = cyc < shadow_until;
        fb  = cyc < flag_until;
        hz  = ins.v && !sh && ((ins.u1 && (cyc < busy_until[ins.rs1]))
                            || (ins.u2 && (cyc < busy_until[ins.rs2]))
                            || (ins.br && fb)
                            || (ins.we && (cyc < busy_until[ins.rd])));
        iss = ins.v && !sh && !hz;

        e.pc_write   = sh || !hz;
        e.if_write   = sh || !hz;
        e.idex_flush = sh || hz;
        e.if_flush   = sh;
        for (int r = 0; r < int'(NUM_REGS); r++) e.busy[r] = cyc < busy_until[r];
        if (!rst) exp_q.push_back(e);

        if (rst) begin
            for (int r = 0; r < int'(NUM_REGS); r++) busy_until[r] = 0;
            flag_until   = 0;
            shadow_until = 0;
            m_stall      = 0;
            m_shadow     = 0;
        end else begin
            if (hz) m_stall++;
            if (sh) m_shadow++;
            if (iss && ins.ld && ins.we) busy_until[ins.rd] = cyc + 1 + int'(LOAD_LAT);
            if (iss && ins.fw) flag_until = cyc + 1 + int'(FLAG_LAT);
            if (iss && ins.br && (BR_SHADOW > 0)) shadow_until = cyc + 1 + int'(BR_SHADOW);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Monitor: compare the DUT's outputs with the queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e            = exp_q.pop_front();
            a.pc_write   = bus_if.pc_write;
            a.if_write   = bus_if.if_write;
            a.idex_flush = bus_if.idex_flush;
            a.if_flush   = bus_if.if_flush;
            a.busy       = bus_if.busy_regs;
            if (!a.pc_write) obs_stalls++;
            if (a.if_flush) obs_flush++;
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs @%0t: got pc=%b ifw=%b idf=%b iff=%b busy=%b, expected pc=%b ifw=%b idf=%b iff=%b busy=%b",
                          $time, a.pc_write, a.if_write, a.idex_flush, a.if_flush, a.busy,
                          e.pc_write, e.if_write, e.idex_flush, e.if_flush, e.busy);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        bit   hz;
        int   s;
        ins_t nop;
        ins_t idle;
        ins_t dep;
        ins_t cur;

        for (int r = 0; r < int'(NUM_REGS); r++) busy_until[r] = 0;
        nop  = mk(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle = mk(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        step(idle, 1'b1, hz);
        step(idle, 1'b1, hz);
        step(idle, 1'b0, hz);

        // Load-use: load r3 then dependent add.
        s = obs_stalls;
        step(mk(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, hz);
        dep = mk(1'b1, 3, 1'b1, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(dep, 1'b0, hz);
            if (!hz) break;
        end
        check_int("load_use_stall_cycles", obs_stalls - s, int'(LOAD_LAT));

        // Flag writer then branch, followed by the branch shadow.
        s = obs_stalls;
        step(mk(1'b1, 1, 1'b1, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, hz);
        for (int k = 0; k < 10; k++) begin
            step(mk(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, hz);
            if (!hz) break;
        end
        check_int("flag_branch_stall_cycles", obs_stalls - s, int'(FLAG_LAT));
        s = obs_flush;
        for (int k = 0; k < 4; k++) step(nop, 1'b0, hz);
        check_int("branch_shadow_cycles", obs_flush - s, int'(BR_SHADOW));

        // WAW against a pending load, no source use.
        s = obs_stalls;
        step(mk(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, hz);
        for (int k = 0; k < 10; k++) begin
            step(mk(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, hz);
            if (!hz) break;
        end
        check_int("waw_stall_cycles", obs_stalls - s, int'(LOAD_LAT));

        // Invalid slot presenting a busy source must not stall.
        step(mk(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, hz);
        s = obs_stalls;
        step(mk(1'b0, 2, 1'b1, 2, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, hz);
        step(mk(1'b0, 2, 1'b1, 2, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, hz);
        check_int("invalid_no_stall", obs_stalls - s, 0);

        // Reset in the middle of a stall discards the pending load.
        step(mk(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, hz);
        dep = mk(1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        s = obs_stalls;
        step(dep, 1'b0, hz);
        check_int("pre_reset_stall", obs_stalls - s, 1);
        step(dep, 1'b1, hz);
        s = obs_stalls;
        step(dep, 1'b0, hz);
        step(nop, 1'b0, hz);
        check_int("post_reset_no_stall", obs_stalls - s, 0);

        // Random traffic; a stalled instruction is held in decode.
        cur = rand_ins();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(cur, 1'b1, hz);
                cur = rand_ins();
            end else begin
                step(cur, 1'b0, hz);
                if (!hz) cur = rand_ins();
            end
        end
        step(idle, 1'b0, hz);

`ifdef HAZ_PERF_CNT_EN
        check_int("perf_stall_cycles", int'(stall_cycles), m_stall);
        check_int("perf_shadow_cycles", int'(shadow_cycles), m_shadow);
`endif
        check_int("expect_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
